mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Responder end of the CPU memory bus: 4 KiB byte RAM serving CPU read requests
//  with a request/ack handshake and single-cycle writes. After every reset it loads
//  the 80-byte hex font into 0x000-0x04F before accepting requests. Sits beside cpu.
// PARAMETERS
//  READ_LATENCY  2      cycles from request accept to read_ack (legal 1..8)
//  FONT_BASE     12'h000  first address of font image
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  read        in   1   read request (level, held until read_ack seen)
//  read_addr   in   12  read byte address
//  read_data   out  8   read result, valid in read_ack cycle, held until next ack
//  read_ack    out  1   one-cycle pulse: read_data valid
//  write       in   1   write strobe, one byte per cycle it is high
//  write_addr  in   12  write byte address
//  write_data  in   8   write byte
//  busy        out  1   high while font load runs; requests/writes not accepted
//  wp_fault    out  1   sticky write-protect violation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: read_data=8'h00, read_ack=0, busy=1, wp_fault=0, state=INIT, load idx=0.
//  RAM array is not cleared by reset; only font region is rewritten.
//  States: INIT -> IDLE -> WAIT -> ACK -> IDLE.
//   INIT: writes font[idx] to FONT_BASE+idx, idx 0..79, one byte/cycle; busy=1;
//         CPU write/read ignored (not queued). After idx=79 write -> IDLE, busy=0.
//   IDLE: read=1 accepts: latch read_addr, load latency counter. READ_LATENCY=1 -> ACK,
//         else -> WAIT.
//   WAIT: counter decrements; -> ACK when accept-to-ACK distance equals READ_LATENCY.
//   ACK:  read_ack=1 for exactly this cycle; read ignored in ACK; -> IDLE. Back-to-back
//         reads: earliest next accept is cycle after ACK.
//  Latency: accept at edge ending cycle N => read_ack high in cycle N+READ_LATENCY.
//  read_data captured on edge entering ACK from latched address; a write to the same
//   address committed on that same edge or earlier is returned (write-first bypass).
//  Writes accepted in IDLE/WAIT/ACK, any cycle write=1, commit on that edge; read and
//   write in same cycle both proceed independently.
//  Address is 12 bits; no wrap or out-of-range case exists. read_addr changes after
//   accept are ignored until next accept.
//  Reset mid-operation (any state): pending read dropped, no ack, font reloaded.
//  Reset overrides a simultaneous write; that write is lost.
// CONFIGURATION
//  MEM_WRITE_PROTECT_EN defined: writes with write_addr < 12'h200 (interpreter area)
//   are dropped; each sets wp_fault=1 (sticky, cleared only by reset). INIT load unaffected.
//  Undefined: all addresses writable; wp_fault tied 0.
// STRUCTURE
//  chip8_pkg: ADDR_W=12, DATA_W=8, MEM_BYTES=4096, FONT_BYTES=80, PROG_BASE=12'h200,
//   state enum encodings, 80-byte font table (sprites 0-F, 5 bytes each).
//  Sub-module font_rom: combinational 7-bit index -> 8-bit font byte from package table.
// TESTING
//  1 Reset, wait busy=0 (81 cycles max) -> read 0x000=F0, 0x004=F0, 0x04F=80, busy 80 cycles.
//  2 READ_LATENCY=2, read 0x000 accepted cycle N -> read_ack only in N+2, one cycle, data F0.
//  3 write 0x300=A5 then read 0x300 -> A5; write 0x301=3C same cycle as read accept of
//    0x301 -> ack returns 3C.
//  4 Read held high through ack -> second ack exactly 1+READ_LATENCY cycles after first;
//    read/write during busy -> no ack, RAM unchanged.
//  5 Reset asserted in WAIT -> no read_ack, busy=1 next cycle, 0x300 keeps A5 after reload.
//  6 MEM_WRITE_PROTECT_EN: write 0x100=77 -> 0x100 unchanged, wp_fault=1 sticky; write
//    0x200=77 -> stored. Undefined: 0x100 becomes 77, wp_fault=0.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types, sizes and the 80-byte hex font image for the CHIP-8 memory responder.
package chip8_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int MEM_BYTES  = 4096;
  localparam int FONT_BYTES = 80;
  localparam logic [11:0] PROG_BASE = 12'h200;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  // Sprites 0-F, five rows each; element 0 is the leftmost entry.
  localparam logic [0:79][7:0] FONT_TABLE = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    logic [7:0] b;
    if (idx < 7'd80) begin
      b = FONT_TABLE[idx];
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

endpackage

// File: rtl/mem_responder_font_rom.sv
// Combinational font ROM: 7-bit load index to the font byte stored at that offset.
module font_rom
  import chip8_pkg::*;
(
  input  logic [6:0] idx,
  output logic [7:0] data
);

  assign data = font_byte(idx);

endmodule

// File: rtl/mem_responder.sv
// 4 KiB byte RAM answering CPU reads with a request/ack handshake; reloads the font after reset.
// Optional write protection of the interpreter area below 0x200: define MEM_WRITE_PROTECT_EN.
module mem_responder
  import chip8_pkg::*;
#(
  parameter int          READ_LATENCY = 2,
  parameter logic [11:0] FONT_BASE    = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [11:0] read_addr,
  output logic [7:0]  read_data,
  output logic        read_ack,
  input  logic        write,
  input  logic [11:0] write_addr,
  input  logic [7:0]  write_data,
  output logic        busy,
  output logic        wp_fault
);

  localparam logic [3:0] WAIT_LOAD = 4'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  read_data_q, read_data_d;
  logic        read_ack_q, read_ack_d;
  logic        busy_q, busy_d;
  logic        wp_fault_q, wp_fault_d;

  logic [7:0]  mem_q [MEM_BYTES];

  logic [7:0]  font_s;
  logic        wp_hit_s;
  logic        cpu_wr_s;
  logic        wr_en_s;
  logic [11:0] wr_addr_s;
  logic [7:0]  wr_data_s;
  logic [11:0] rd_addr_s;
  logic [7:0]  rd_byte_s;

  font_rom u_font_rom (
    .idx  (idx_q),
    .data (font_s)
  );

  always_comb begin
    wp_hit_s = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
    wp_hit_s = (write_addr < PROG_BASE);
`endif
    cpu_wr_s = write && (state_q != ST_INIT) && !wp_hit_s;

    // Font load owns the write port during INIT; reset suppresses every write.
    if (reset) begin
      wr_en_s   = 1'b0;
      wr_addr_s = write_addr;
      wr_data_s = write_data;
    end else if (state_q == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_addr_s = FONT_BASE + {5'd0, idx_q};
      wr_data_s = font_s;
    end else begin
      wr_en_s   = cpu_wr_s;
      wr_addr_s = write_addr;
      wr_data_s = write_data;
    end

    // In IDLE the address has not been latched yet (latency-1 path).
    rd_addr_s = (state_q == ST_IDLE) ? read_addr : addr_q;
    rd_byte_s = (cpu_wr_s && (write_addr == rd_addr_s)) ? write_data : mem_q[rd_addr_s];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    read_data_d = read_data_q;
    read_ack_d  = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_INIT: begin
        if (idx_q == 7'(FONT_BYTES - 1)) begin
          idx_d   = 7'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 7'd1;
        end
      end
      ST_IDLE: begin
        if (read) begin
          addr_d = read_addr;
          cnt_d  = WAIT_LOAD;
          if (READ_LATENCY == 1) begin
            read_ack_d  = 1'b1;
            read_data_d = rd_byte_s;
            state_d     = ST_ACK;
          end else begin
            state_d     = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          read_ack_d  = 1'b1;
          read_data_d = rd_byte_s;
          state_d     = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = 7'd0;
        busy_d  = 1'b1;
      end
    endcase

`ifdef MEM_WRITE_PROTECT_EN
    wp_fault_d = wp_fault_q | (write && (state_q != ST_INIT) && wp_hit_s);
`else
    wp_fault_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      idx_q       <= 7'd0;
      cnt_q       <= 4'd0;
      addr_q      <= 12'h000;
      read_data_q <= 8'h00;
      read_ack_q  <= 1'b0;
      busy_q      <= 1'b1;
      wp_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      read_data_q <= read_data_d;
      read_ack_q  <= read_ack_d;
      busy_q      <= busy_d;
      wp_fault_q  <= wp_fault_d;
    end
  end

  // RAM contents survive reset; only the font region is rewritten by INIT.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign read_data = read_data_q;
  assign read_ack  = read_ack_q;
  assign busy      = busy_q;
  assign wp_fault  = wp_fault_q;

endmodule
